lsu_mem_master: RTL and testbench

- Load/store initiator between the core's memory stage and the DPI-backed data RAM port (valid / writeEnable / writeAddr / writeData / writeMask / readAddr / readData).
- Accepts one load or store at a time from the core and issues a single word-aligned RAM access with lane-shifted data and a byte mask.
- Waits a fixed RAM latency, then extracts, extends and returns load data through a valid/ready response channel.
- Misaligned accesses are rejected with an error response and never reach the RAM.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_mem_master_if.sv | 31 +++
 rtl/lsu_load_align.sv | 10 +
 rtl/lsu_mem_master.sv | 96 +++++++++
 tb/tb_lsu_mem_master.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM state enum and lane/extension helpers for the load/store unit
package lsu_pkg;
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == SIZE_W ? |off : size == SIZE_H ? off[0] : size == 2'd3;
  endfunction
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    return size == SIZE_B ? 4'b0001 << off : size == SIZE_H ? 4'b0011 << off : 4'hF;
  endfunction
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [1:0] off, input logic [31:0] d);
    return size == SIZE_B ? {24'b0, d[7:0]} << {off, 3'b000} :
           size == SIZE_H ? {16'b0, d[15:0]} << {off, 3'b000} : d;
  endfunction
  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [1:0] off, input logic uns, input logic [31:0] word);
    logic [31:0] s;
    s = word >> {off, 3'b000};
    return size == SIZE_B ? {{24{~uns & s[7]}}, s[7:0]} :
           size == SIZE_H ? {{16{~uns & s[15]}}, s[15:0]} : s;
  endfunction
endpackage

// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if: core req/resp channels plus RAM port; master = load/store unit, slave = core and RAM side
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_write_enable;
  logic [31:0] mem_write_addr;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_mask;
  logic [31:0] mem_read_addr;
  logic [31:0] mem_read_data;
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready, mem_read_data,
    output req_ready, resp_valid, resp_data, resp_err,
           mem_valid, mem_write_enable, mem_write_addr, mem_write_data, mem_write_mask, mem_read_addr
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready, mem_read_data,
    input  req_ready, resp_valid, resp_data, resp_err,
           mem_valid, mem_write_enable, mem_write_addr, mem_write_data, mem_write_mask, mem_read_addr
  );
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: shifts a RAM word down to the access lane and sign/zero-extends it (size_i, off_i, unsigned_i, word_i -> data_o)
module lsu_load_align import lsu_pkg::*; (
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);
  assign data_o = load_extend(size_i, off_i, unsigned_i, word_i);
endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store initiator; clock/reset plus bus (core req/resp channels, word-aligned RAM port)
module lsu_mem_master import lsu_pkg::*; #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic clock,
  input  logic reset,
  lsu_mem_master_if.master bus
);
  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] ISSUE = ST_ISSUE;
  localparam logic [1:0] WAIT  = ST_WAIT;
  localparam logic [1:0] RESP  = ST_RESP;
  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q, resp_data_q, resp_data_d, load_data;
  logic [1:0]  size_q;
  logic        write_q, uns_q, resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic        acc, bad, iss, st;
  assign acc = bus.req_valid && bus.req_ready;
  assign bad = misaligned(bus.req_size, bus.req_addr[1:0]);
  assign iss = state_q == ISSUE;
  assign st  = iss && write_q;
  assign bus.req_ready        = state_q == IDLE && !reset;
  assign bus.resp_valid       = resp_valid_q;
  assign bus.resp_data        = resp_data_q;
  assign bus.resp_err         = resp_err_q;
  assign bus.mem_valid        = iss;
  assign bus.mem_write_enable = st;
  assign bus.mem_write_addr   = iss ? {addr_q[31:2], 2'b00} : '0;
  assign bus.mem_read_addr    = bus.mem_write_addr;
  assign bus.mem_write_data   = st ? lane_wdata(size_q, addr_q[1:0], wdata_q) : '0;
  assign bus.mem_write_mask   = st ? lane_mask(size_q, addr_q[1:0]) : '0;
  lsu_load_align u_align (
    .size_i     (size_q),
    .off_i      (addr_q[1:0]),
    .unsigned_i (uns_q),
    .word_i     (bus.mem_read_data),
    .data_o     (load_data)
  );
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_data_d  = resp_data_q;
    if (state_q == IDLE && acc) begin
      state_d      = bad ? RESP : ISSUE;
      resp_valid_d = bad;
      resp_err_d   = bad;
      resp_data_d  = '0;
    end else if (state_q == ISSUE) begin
      state_d = WAIT;
      cnt_d   = 3'(MEM_LATENCY - 1);
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - 3'd1;
      if (cnt_q == 3'd0) begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_data_d  = write_q ? '0 : load_data;
      end
    end else if (state_q == RESP && bus.resp_ready) begin
      state_d      = IDLE;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_data_d  = '0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      write_q      <= 1'b0;
      uns_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
      if (acc) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        size_q  <= bus.req_size;
        write_q <= bus.req_write;
        uns_q   <= bus.req_unsigned;
      end
    end
  end
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed and reference-model checks of lsu_mem_master at MEM_LATENCY 1 and 3
module tb_lsu_mem_master;
  logic clock = 1'b0;
  logic rst1, rst3;
  int n_cmp = 0, n_bad = 0, n_mv1 = 0, n_mv3 = 0;
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] p0, p1;
  logic        cap_we;
  logic [31:0] cap_wa, cap_ra, cap_wd;
  logic [3:0]  cap_mask;
  lsu_mem_master_if b1();
  lsu_mem_master_if b3();
  lsu_mem_master #(.MEM_LATENCY(1)) u_dut1 (.clock(clock), .reset(rst1), .bus(b1.master));
  lsu_mem_master #(.MEM_LATENCY(3)) u_dut3 (.clock(clock), .reset(rst3), .bus(b3.master));
  always #5 clock = ~clock;
  function automatic logic [31:0] init_word(input int i);
    return 32'h1357_9BDF ^ (32'(i) * 32'h0102_0408);
  endfunction
  always_ff @(posedge clock) begin
    if (rst1) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else if (b1.mem_valid && b1.mem_write_enable) begin
      for (int k = 0; k < 4; k++)
        if (b1.mem_write_mask[k]) mem[b1.mem_write_addr[5:2]][8*k +: 8] <= b1.mem_write_data[8*k +: 8];
    end
    b1.mem_read_data <= b1.mem_valid ? mem[b1.mem_read_addr[5:2]] : 32'hBAD0_BAD0;
    n_mv1 <= n_mv1 + (b1.mem_valid ? 1 : 0);
  end
  always_ff @(posedge clock) begin
    p0 <= b3.mem_valid ? mem[b3.mem_read_addr[5:2]] : 32'hBAD0_BAD0;
    p1 <= p0;
    b3.mem_read_data <= p1;
    n_mv3 <= n_mv3 + (b3.mem_valid ? 1 : 0);
  end
  always @(negedge clock) begin
    if (b1.mem_valid) begin
      cap_we   <= b1.mem_write_enable;
      cap_wa   <= b1.mem_write_addr;
      cap_ra   <= b1.mem_read_addr;
      cap_wd   <= b1.mem_write_data;
      cap_mask <= b1.mem_write_mask;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic txn(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                     input logic uns, input logic [31:0] exp_d, input logic exp_e, input int exp_lat, input int hold);
    int w, lat;
    w = 0;
    while (!b1.req_ready && w < 20) begin @(negedge clock); w++; end
    check("req_ready", b1.req_ready, 1);
    b1.req_valid = 1'b1; b1.req_write = wr; b1.req_size = sz; b1.req_addr = a;
    b1.req_wdata = wd; b1.req_unsigned = uns;
    @(posedge clock);
    @(negedge clock);
    b1.req_valid = 1'b0;
    lat = 1;
    while (!b1.resp_valid && lat < 30) begin @(negedge clock); lat++; end
    check("resp_seen", b1.resp_valid, 1);
    check("lat", 32'(lat), 32'(exp_lat));
    check("resp_data", b1.resp_data, exp_d);
    check("resp_err", b1.resp_err, exp_e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("bp_valid", b1.resp_valid, 1);
      check("bp_data", b1.resp_data, exp_d);
      check("bp_ready", b1.req_ready, 0);
    end
    b1.resp_ready = 1'b1;
    @(negedge clock);
    b1.resp_ready = 1'b0;
    check("resp_clr", b1.resp_valid, 0);
  endtask
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz, input logic [1:0] off, input logic uns);
    logic [7:0] b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    if (sz == 2'd0) return uns ? {24'h0, b} : {{24{b[7]}}, b};
    if (sz == 2'd1) return uns ? {16'h0, h} : {{16{h[15]}}, h};
    return w;
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int mv0, lat, n_al, r;
    logic wr, uns, bad;
    logic [1:0] sz, off;
    logic [3:0] idx;
    logic [31:0] a, wd, exp;
    rst1 = 1'b1; rst3 = 1'b1;
    b1.req_valid = 0; b1.req_write = 0; b1.req_addr = 0; b1.req_wdata = 0; b1.req_size = 0; b1.req_unsigned = 0; b1.resp_ready = 0;
    b3.req_valid = 0; b3.req_write = 0; b3.req_addr = 0; b3.req_wdata = 0; b3.req_size = 0; b3.req_unsigned = 0; b3.resp_ready = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_req_ready", b1.req_ready, 0);
    check("rst_mem_valid", b1.mem_valid, 0);
    check("rst_mask", b1.mem_write_mask, 0);
    check("rst_resp_valid", b1.resp_valid, 0);
    check("rst_resp_data", b1.resp_data, 0);
    check("rst_resp_err", b1.resp_err, 0);
    rst1 = 1'b0; rst3 = 1'b0;
    @(negedge clock);
    check("idle_req_ready", b1.req_ready, 1);
    mv0 = n_mv1;
    txn(1, 2'd0, 32'h8000_0003, 32'h0000_00AB, 0, 32'h0, 0, 3, 0);
    check("sb_pulses", 32'(n_mv1 - mv0), 1);
    check("sb_we", cap_we, 1);
    check("sb_waddr", cap_wa, 32'h8000_0000);
    check("sb_raddr", cap_ra, 32'h8000_0000);
    check("sb_mask", cap_mask, 4'b1000);
    check("sb_wdata", cap_wd, 32'hAB00_0000);
    txn(1, 2'd2, 32'h8000_0000, 32'h8123_4567, 0, 32'h0, 0, 3, 0);
    check("sw_mask", cap_mask, 4'hF);
    check("sw_wdata", cap_wd, 32'h8123_4567);
    txn(0, 2'd1, 32'h8000_0002, 32'h0, 0, 32'hFFFF_8123, 0, 3, 0);
    check("lh_we", cap_we, 0);
    check("lh_mask", cap_mask, 4'h0);
    check("lh_raddr", cap_ra, 32'h8000_0000);
    txn(0, 2'd1, 32'h8000_0002, 32'h0, 1, 32'h0000_8123, 0, 3, 0);
    txn(1, 2'd1, 32'h8000_0006, 32'h0000_BEEF, 0, 32'h0, 0, 3, 0);
    check("sh_mask", cap_mask, 4'b1100);
    check("sh_wdata", cap_wd, 32'hBEEF_0000);
    mv0 = n_mv1;
    txn(0, 2'd2, 32'h8000_0001, 32'h0, 0, 32'h0, 1, 1, 0);
    txn(0, 2'd3, 32'h8000_0000, 32'h0, 0, 32'h0, 1, 1, 0);
    check("mis_pulses", 32'(n_mv1 - mv0), 0);
    txn(1, 2'd2, 32'h8000_0008, 32'hDEAD_BEEF, 0, 32'h0, 0, 3, 0);
    mv0 = n_mv1;
    txn(0, 2'd2, 32'h8000_0008, 32'h0, 0, 32'hDEAD_BEEF, 0, 3, 5);
    check("bp_pulses", 32'(n_mv1 - mv0), 1);
    txn(1, 2'd2, 32'h8000_0000, 32'h0000_7F00, 0, 32'h0, 0, 3, 0);
    b3.req_valid = 1'b1; b3.req_write = 0; b3.req_addr = 32'h8000_0004; b3.req_size = 2'd2; b3.req_unsigned = 0;
    @(posedge clock);
    @(negedge clock);
    b3.req_valid = 1'b0;
    check("r3_issue", b3.mem_valid, 1);
    @(negedge clock);
    rst3 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("r3_req_ready", b3.req_ready, 0);
    check("r3_mem_valid", b3.mem_valid, 0);
    check("r3_raddr", b3.mem_read_addr, 0);
    check("r3_resp_valid", b3.resp_valid, 0);
    check("r3_resp_data", b3.resp_data, 0);
    check("r3_resp_err", b3.resp_err, 0);
    rst3 = 1'b0;
    @(negedge clock);
    check("r3_idle", b3.req_ready, 1);
    b3.req_valid = 1'b1; b3.req_addr = 32'h8000_0001; b3.req_size = 2'd0; b3.req_unsigned = 0;
    @(posedge clock);
    @(negedge clock);
    b3.req_valid = 1'b0;
    lat = 1;
    while (!b3.resp_valid && lat < 30) begin @(negedge clock); lat++; end
    check("r3_lat", 32'(lat), 5);
    check("r3_data", b3.resp_data, 32'h0000_007F);
    check("r3_err", b3.resp_err, 0);
    b3.resp_ready = 1'b1;
    @(negedge clock);
    b3.resp_ready = 1'b0;
    check("r3_pulses", 32'(n_mv3), 2);
    rst1 = 1'b1;
    repeat (2) @(negedge clock);
    rst1 = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    @(negedge clock);
    mv0 = n_mv1;
    n_al = 0;
    for (int t = 0; t < 1000; t++) begin
      r   = int'($urandom_range(0, 9));
      sz  = r < 3 ? 2'd0 : r < 6 ? 2'd1 : r < 9 ? 2'd2 : 2'd3;
      a   = 32'h8000_0000 | 32'($urandom_range(0, 63));
      wr  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      wd  = $urandom;
      idx = a[5:2];
      off = a[1:0];
      bad = sz == 2'd3 || (sz == 2'd2 && off != 2'd0) || (sz == 2'd1 && off[0]);
      exp = 32'h0;
      if (!bad) begin
        n_al++;
        if (!wr) exp = ref_load(ref_mem[idx], sz, off, uns);
        else if (sz == 2'd0) ref_mem[idx][{off, 3'b000} +: 8] = wd[7:0];
        else if (sz == 2'd1) ref_mem[idx][{off[1], 4'b0000} +: 16] = wd[15:0];
        else ref_mem[idx] = wd;
      end
      txn(wr, sz, a, wd, uns, exp, bad, bad ? 1 : 3, 0);
    end
    check("rand_pulses", 32'(n_mv1 - mv0), 32'(n_al));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
